// File: rtl/svreal_accum_pkg.sv
// Shared types and helpers for the svreal accumulate stage: FSM state encoding,
// accumulator range limits and the input-to-accumulator exponent shift.
package svreal_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic longint acc_max(input int width);
        return (longint'(1) << (width - 1)) - longint'(1);
    endfunction

    function automatic longint acc_min(input int width);
        return -(longint'(1) << (width - 1));
    endfunction

    // Positive result: input LSB weighs more than accumulator LSB, shift left.
    function automatic int align_shift(input int in_exp, input int acc_exp);
        return in_exp - acc_exp;
    endfunction

endpackage

// File: rtl/svreal_align.sv
// Combinational format conversion: sign-extend a signed code to the wider
// accumulator width, then shift by SHIFT (left if >= 0, arithmetic right if < 0).
module svreal_align #(
    parameter int IN_WIDTH  = 18,
    parameter int ACC_WIDTH = 32,
    parameter int SHIFT     = 0
) (
    input  logic signed [IN_WIDTH-1:0]  value_i,
    output logic signed [ACC_WIDTH-1:0] value_o
);

    logic signed [ACC_WIDTH-1:0] ext;

    assign ext = ACC_WIDTH'(value_i);

    // Right shifts floor toward -inf; bits pushed past the top on a left shift are dropped.
    generate
        if (SHIFT >= 0) begin : g_left
            assign value_o = ext <<< SHIFT;
        end else begin : g_right
            assign value_o = ext >>> (-SHIFT);
        end
    endgenerate

endmodule

// File: rtl/svreal_accum.sv
// Block accumulator: sums len consecutive fixed-point samples and presents one
// result under valid/ready. Define SVREAL_ACCUM_SAT_EN for saturating arithmetic.
module svreal_accum
    import svreal_accum_pkg::*;
#(
    parameter int IN_WIDTH     = 18,
    parameter int IN_EXPONENT  = -12,
    parameter int ACC_WIDTH    = 32,
    parameter int ACC_EXPONENT = -12,
    parameter int LEN_WIDTH    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [IN_WIDTH-1:0]  in_value,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LEN_WIDTH-1:0]        len,
    output logic signed [ACC_WIDTH-1:0] out_value,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_ovf
);

    localparam int SHIFT = align_shift(IN_EXPONENT, ACC_EXPONENT);

    state_e                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [LEN_WIDTH-1:0]        cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]        total_q, total_d;
    logic                        ovf_q, ovf_d;

    logic signed [ACC_WIDTH-1:0] aligned;
    logic signed [ACC_WIDTH-1:0] step_acc;
    logic                        step_ovf;
    logic [LEN_WIDTH-1:0]        first_total;
    logic [LEN_WIDTH-1:0]        cnt_inc;
    logic                        in_xfer;

    svreal_align #(
        .IN_WIDTH  (IN_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .SHIFT     (SHIFT)
    ) u_align (
        .value_i (in_value),
        .value_o (aligned)
    );

`ifdef SVREAL_ACCUM_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(acc_max(ACC_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(acc_min(ACC_WIDTH));

    logic signed [ACC_WIDTH:0] sum_wide;

    // One guard bit: the top two bits disagree exactly when the true sum leaves the range.
    assign sum_wide = {acc_q[ACC_WIDTH-1], acc_q} + {aligned[ACC_WIDTH-1], aligned};
    assign step_ovf = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
    assign step_acc = step_ovf ? (sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                               : sum_wide[ACC_WIDTH-1:0];
`else
    assign step_acc = acc_q + aligned;
    assign step_ovf = 1'b0;
`endif

    assign first_total = (len == '0) ? LEN_WIDTH'(1) : len;
    assign cnt_inc     = cnt_q + LEN_WIDTH'(1);

    assign in_ready  = rst_n && (state_q != DONE);
    assign out_valid = rst_n && (state_q == DONE);
    assign out_value = rst_n ? acc_q : '0;
    assign out_ovf   = rst_n && ovf_q;
    assign in_xfer   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    total_d = first_total;
                    acc_d   = aligned;
                    cnt_d   = LEN_WIDTH'(1);
                    ovf_d   = 1'b0;
                    state_d = (first_total == LEN_WIDTH'(1)) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_xfer) begin
                    acc_d = step_acc;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | step_ovf;
                    if (cnt_inc == total_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            total_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_svreal_accum.sv
// Bench for svreal_accum: three configurations driven in lockstep (base, ACC_EXPONENT=-6,
// ACC_WIDTH=16), directed vector table, handwritten corner sequences, random blocks vs model.
module tb_svreal_accum;

`ifdef SVREAL_ACCUM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic signed [15:0] in_value;
    logic               in_valid;
    logic [7:0]         len;
    logic               out_ready;

    logic               in_ready_a, in_ready_b, in_ready_c;
    logic               out_valid_a, out_valid_b, out_valid_c;
    logic               out_ovf_a, out_ovf_b, out_ovf_c;
    logic signed [23:0] out_value_a, out_value_b;
    logic signed [15:0] out_value_c;

    int n_checks = 0;
    int n_errors = 0;

    logic [66:0] exp_q[$];

    typedef struct packed {
        int              n;
        int              len0;
        int              len1;
        logic [3:0][31:0] v;
        int              ea;
        int              eb;
        int              ec;
        int              eovc;
    } vec_t;

    vec_t tbl[8];

    svreal_accum #(.IN_WIDTH(16), .IN_EXPONENT(-8), .ACC_WIDTH(24), .ACC_EXPONENT(-8), .LEN_WIDTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_value(in_value), .in_valid(in_valid), .in_ready(in_ready_a),
        .len(len), .out_value(out_value_a), .out_valid(out_valid_a), .out_ready(out_ready), .out_ovf(out_ovf_a));

    svreal_accum #(.IN_WIDTH(16), .IN_EXPONENT(-8), .ACC_WIDTH(24), .ACC_EXPONENT(-6), .LEN_WIDTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_value(in_value), .in_valid(in_valid), .in_ready(in_ready_b),
        .len(len), .out_value(out_value_b), .out_valid(out_valid_b), .out_ready(out_ready), .out_ovf(out_ovf_b));

    svreal_accum #(.IN_WIDTH(16), .IN_EXPONENT(-8), .ACC_WIDTH(16), .ACC_EXPONENT(-8), .LEN_WIDTH(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_value(in_value), .in_valid(in_valid), .in_ready(in_ready_c),
        .len(len), .out_value(out_value_c), .out_valid(out_valid_c), .out_ready(out_ready), .out_ovf(out_ovf_c));

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "time limit");
    end

    // ---------------- reference model ----------------
    function automatic longint wrap_to(input longint x, input int w);
        longint m, r;
        m = longint'(1) << w;
        r = x % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    function automatic longint scale(input longint x, input int s);
        longint d, r;
        if (s >= 0) return x * (longint'(1) << s);
        d = longint'(1) << (-s);
        r = x % d;
        if (r < 0) r += d;
        return (x - r) / d;
    endfunction

    function automatic longint model_block(input int smp[$], input int s, input int w, output bit ovf);
        longint hi, lo, acc, t;
        hi  = (longint'(1) << (w - 1)) - 1;
        lo  = -(longint'(1) << (w - 1));
        ovf = 1'b0;
        acc = wrap_to(scale(smp[0], s), w);
        for (int i = 1; i < smp.size(); i++) begin
            t = acc + wrap_to(scale(smp[i], s), w);
            if (SAT && t > hi) begin
                acc = hi; ovf = 1'b1;
            end else if (SAT && t < lo) begin
                acc = lo; ovf = 1'b1;
            end else begin
                acc = wrap_to(t, w);
            end
        end
        return acc;
    endfunction

    function automatic logic [66:0] make_exp(input longint a, input longint b, input longint c,
                                             input bit ova, input bit ovb, input bit ovc);
        return {ovc, ovb, ova, 16'(c), 24'(b), 24'(a)};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic flag_timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic compare_got(input string tag, input logic [66:0] got, input logic [66:0] exp);
        check({tag, "_val_a"}, longint'($signed(got[23:0])),  longint'($signed(exp[23:0])));
        check({tag, "_val_b"}, longint'($signed(got[47:24])), longint'($signed(exp[47:24])));
        check({tag, "_val_c"}, longint'($signed(got[63:48])), longint'($signed(exp[63:48])));
        check({tag, "_ovf_a"}, longint'(got[64]), longint'(exp[64]));
        check({tag, "_ovf_b"}, longint'(got[65]), longint'(exp[65]));
        check({tag, "_ovf_c"}, longint'(got[66]), longint'(exp[66]));
    endtask

    // ---------------- drivers ----------------
    task automatic push(input int v, input int l);
        int t;
        t = 0;
        in_value = 16'(v);
        len      = 8'(l);
        in_valid = 1'b1;
        while (!(in_ready_a && in_ready_b && in_ready_c) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) flag_timeout("push");
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic get_result(input int hold, output logic [66:0] got);
        int t;
        logic signed [23:0] held;
        t   = 0;
        got = '0;
        while (!out_valid_a && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) begin
            flag_timeout("get_result");
            return;
        end
        check("valid_lockstep", longint'({out_valid_b, out_valid_c}), 3);
        held = out_value_a;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_stable", out_value_a, held);
            check("hold_in_ready", longint'(in_ready_a), 0);
        end
        got = {out_ovf_c, out_ovf_b, out_ovf_a, out_value_c, out_value_b, out_value_a};
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", longint'(out_valid_a), 0);
    endtask

    task automatic set_vec(input int k, input int n, input int l0, input int l1,
                           input int v0, input int v1, input int v2, input int v3,
                           input int ea, input int eb, input int ec, input int eovc);
        tbl[k].n = n; tbl[k].len0 = l0; tbl[k].len1 = l1;
        tbl[k].v[0] = v0; tbl[k].v[1] = v1; tbl[k].v[2] = v2; tbl[k].v[3] = v3;
        tbl[k].ea = ea; tbl[k].eb = eb; tbl[k].ec = ec; tbl[k].eovc = eovc;
    endtask

    // ---------------- test ----------------
    initial begin
        logic [66:0] got;
        logic [66:0] exp;
        int          smp[$];
        int          len_v, n;
        bit          ova, ovb, ovc;
        longint      ea, eb, ec;

        set_vec(0, 3, 3, 3,   384,    576, -128, 0,   832,    208,    832, 0);
        set_vec(1, 1, 1, 1,   384,      0,    0, 0,   384,     96,    384, 0);
        set_vec(2, 1, 1, 1,    -1,      0,    0, 0,    -1,     -1,     -1, 0);
        set_vec(3, 1, 1, 1,     3,      0,    0, 0,     3,      0,      3, 0);
        set_vec(4, 1, 0, 0,   100,      0,    0, 0,   100,     25,    100, 0);
        set_vec(5, 2, 2, 2, 32767,  32767,    0, 0, 65534,  16382,
                SAT ? 32767 : -2, SAT ? 1 : 0);
        set_vec(6, 3, 3, 3, -32768, -32768, 100, 0, -65436, -16359,
                SAT ? -32668 : 100, SAT ? 1 : 0);
        set_vec(7, 2, 2, 5,    10,     20,    0, 0,    30,      7,     30, 0);

        rst_n = 1'b0; in_valid = 1'b0; in_value = '0; len = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", longint'(in_ready_a), 0);
        check("reset_out_valid", longint'(out_valid_a), 0);
        check("reset_out_value", out_value_a, 0);
        check("reset_out_ovf", longint'(out_ovf_c), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", longint'(in_ready_a), 1);
        check("idle_out_valid", longint'(out_valid_a), 0);

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < tbl[k].n; i++) begin
                push($signed(tbl[k].v[i]), (i == 0) ? tbl[k].len0 : tbl[k].len1);
            end
            check($sformatf("latency_valid_%0d", k), longint'(out_valid_a), 1);
            check($sformatf("done_in_ready_%0d", k), longint'(in_ready_a), 0);
            get_result(0, got);
            compare_got($sformatf("vec%0d", k), got,
                        make_exp(tbl[k].ea, tbl[k].eb, tbl[k].ec, 1'b0, 1'b0, tbl[k].eovc != 0));
        end

        // backpressure: result held, offered input refused while DONE
        push(7, 1);
        in_value = 16'sd99;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", longint'(out_valid_a), 1);
            check("bp_value", out_value_a, 7);
            check("bp_in_ready", longint'(in_ready_a), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_in_ready", longint'(in_ready_a), 1);
        check("bp_release_valid", longint'(out_valid_a), 0);
        in_valid = 1'b0;
        push(11, 1);
        get_result(0, got);
        compare_got("bp_next", got, make_exp(11, 2, 11, 1'b0, 1'b0, 1'b0));

        // reset in the middle of a block discards it
        push(1000, 4);
        push(2000, 7);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", longint'(in_ready_a), 0);
        check("midrst_out_valid", longint'(out_valid_a), 0);
        check("midrst_out_value", out_value_a, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_stale", longint'(out_valid_a), 0);
        end
        push(5, 1);
        get_result(0, got);
        compare_got("midrst_new", got, make_exp(5, 1, 5, 1'b0, 1'b0, 1'b0));

        // random blocks against the reference model
        for (int blk = 0; blk < 31; blk++) begin
            smp.delete();
            if (blk == 30) begin
                len_v = 255;
                for (int i = 0; i < 255; i++) smp.push_back(int'($urandom_range(0, 200)) - 100);
            end else begin
                len_v = int'($urandom_range(0, 6));
                n = (len_v == 0) ? 1 : len_v;
                for (int i = 0; i < n; i++) smp.push_back(int'($urandom_range(0, 65535)) - 32768);
            end
            ea = model_block(smp, 0, 24, ova);
            eb = model_block(smp, -2, 24, ovb);
            ec = model_block(smp, 0, 16, ovc);
            exp_q.push_back(make_exp(ea, eb, ec, ova, ovb, ovc));
            for (int i = 0; i < smp.size(); i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                push(smp[i], (i == 0) ? len_v : int'($urandom_range(0, 255)));
            end
            get_result(int'($urandom_range(0, 3)), got);
            exp = exp_q.pop_front();
            compare_got($sformatf("rand%0d", blk), got, exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
